// File: rtl/core_if_inst_queue_pkg.sv
// Shared definitions for the fetch->decode instruction queue.
//   CORE_PC_WIDTH / CORE_INST_WIDTH : default datapath widths
//   Entry layout (LSB first): branch_predict | inst | pc
//   ifq_entry_w / ifq_pc_lsb        : entry width and pc field offset
package core_if_inst_queue_pkg;

  localparam int CORE_PC_WIDTH   = 32;
  localparam int CORE_INST_WIDTH = 32;

  localparam int IFQ_PRED_BIT = 0;
  localparam int IFQ_INST_LSB = 1;

  // CORE_IFQ_ENTRY_WIDTH for arbitrary widths
  function automatic int ifq_entry_w(input int pc_w, input int inst_w);
    return pc_w + inst_w + 1;
  endfunction

  function automatic int ifq_pc_lsb(input int inst_w);
    return IFQ_INST_LSB + inst_w;
  endfunction

  localparam int CORE_IFQ_ENTRY_WIDTH = CORE_PC_WIDTH + CORE_INST_WIDTH + 1;

endpackage

// File: rtl/core_ifq_ram.sv
// DEPTH x ENTRY_W register array, one synchronous write port and one
// asynchronous read port. Contents reset to zero.
//   clk, rst_n      : clock, async active-low reset
//   we/waddr/wdata  : write port
//   raddr/rdata     : combinational read port
module core_ifq_ram #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 65,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/core_if_inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of
// {pc, inst, branch_predict} with optional empty-queue bypass and
// single-cycle flush.
//   valid_in/ready_in/i_*     : fetch side handshake + entry
//   valid_out/ready_out/o_*   : decode side handshake + head entry
//   i_pipe_flush_req          : drop every entry, blocks both handshakes
//   o_count/o_empty/o_full    : occupancy status
module core_if_inst_queue
  import core_if_inst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = CORE_PC_WIDTH,
  parameter int INST_W = CORE_INST_WIDTH,
  parameter int BYPASS = 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_branch_predict,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_branch_predict,
  input  logic              i_pipe_flush_req,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ifq_entry_w(PC_W, INST_W);
  localparam int PC_LSB  = ifq_pc_lsb(INST_W);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ENTRY_W-1:0] wdata, rdata;
  logic empty, full, byp_act, byp_pass;
  logic enq, deq, enq_st, deq_st;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Ready never looks at ready_out: no ready_out->ready_in path.
  assign ready_in = !full && !i_pipe_flush_req;

  // Bypass presents the incoming entry while the queue is empty.
  assign byp_act  = (BYPASS != 0) && empty && valid_in && !i_pipe_flush_req;
  assign valid_out = !i_pipe_flush_req && (!empty || byp_act);

  assign enq = valid_in && ready_in;
  assign deq = valid_out && ready_out;

  // A consumed bypass entry never touches storage or the counters.
  assign byp_pass = byp_act && ready_out;
  assign enq_st   = enq && !byp_pass;
  assign deq_st   = deq && !byp_pass;

  assign wdata = {i_pc, i_inst, i_branch_predict};

  always_comb begin
    if (byp_act) begin
      o_pc             = i_pc;
      o_inst           = i_inst;
      o_branch_predict = i_branch_predict;
    end else begin
      o_pc             = rdata[PC_LSB +: PC_W];
      o_inst           = rdata[IFQ_INST_LSB +: INST_W];
      o_branch_predict = rdata[IFQ_PRED_BIT];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_pipe_flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_st) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_st) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(enq_st) - CNT_W'(deq_st);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // enq is already masked by flush through ready_in.
  core_ifq_ram #(
    .DEPTH  (DEPTH),
    .ENTRY_W(ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (enq_st),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign o_count = cnt_q;
  assign o_empty = empty;
  assign o_full  = full;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q <= CNT_W'(DEPTH)) else $error("ifq count overflow");
      assert (!(enq && full))         else $error("ifq enq while full");
      assert (!(deq && !valid_out))   else $error("ifq deq without valid");
    end
  end
`endif

endmodule

// File: tb/tb_core_if_inst_queue.sv
module tb_core_if_inst_queue;

  logic        clk, rst_n;
  logic        valid_in, ready_in, i_bp, valid_out, ready_out, o_bp, flush;
  logic [31:0] i_pc, i_inst, o_pc, o_inst;
  logic [2:0]  o_count;
  logic        o_empty, o_full;

  logic        nb_valid_in, nb_ready_in, nb_i_bp, nb_valid_out, nb_ready_out, nb_o_bp, nb_flush;
  logic [31:0] nb_i_pc, nb_i_inst, nb_o_pc, nb_o_inst;
  logic [2:0]  nb_o_count;
  logic        nb_o_empty, nb_o_full;

  int total = 0;
  int bad   = 0;

  core_if_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in),
    .i_pc(i_pc), .i_inst(i_inst), .i_branch_predict(i_bp),
    .valid_out(valid_out), .ready_out(ready_out),
    .o_pc(o_pc), .o_inst(o_inst), .o_branch_predict(o_bp),
    .i_pipe_flush_req(flush),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  core_if_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n),
    .valid_in(nb_valid_in), .ready_in(nb_ready_in),
    .i_pc(nb_i_pc), .i_inst(nb_i_inst), .i_branch_predict(nb_i_bp),
    .valid_out(nb_valid_out), .ready_out(nb_ready_out),
    .o_pc(nb_o_pc), .o_inst(nb_o_inst), .o_branch_predict(nb_o_bp),
    .i_pipe_flush_req(nb_flush),
    .o_count(nb_o_count), .o_empty(nb_o_empty), .o_full(nb_o_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive point: 1 after rising edge; sample point: falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #4;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 0; i_pc = 0; i_inst = 0; i_bp = 0; ready_out = 0; flush = 0;
    nb_valid_in = 0; nb_i_pc = 0; nb_i_inst = 0; nb_i_bp = 0; nb_ready_out = 0; nb_flush = 0;
    #2;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_o_pc", o_pc, 0);
    chk("rst_o_inst", o_inst, 0);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_ready_in", ready_in, 1);
    tick(); tick();
    rst_n = 1'b1;

    // bypass pass-through
    tick();
    valid_in = 1; i_pc = 32'h8000_0000; i_inst = 32'h0000_0013; i_bp = 1; ready_out = 1;
    smp();
    chk("byp_valid_out", valid_out, 1);
    chk("byp_o_pc", o_pc, 32'h8000_0000);
    chk("byp_o_inst", o_inst, 32'h13);
    chk("byp_o_bp", o_bp, 1);
    chk("byp_count", o_count, 0);
    tick();
    valid_in = 0; i_bp = 0;
    smp();
    chk("byp_after_count", o_count, 0);
    chk("byp_after_valid", valid_out, 0);

    // fill to full with decode stalled
    ready_out = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      valid_in = 1; i_pc = 32'h100 + 32'(4 * i);
    end
    tick();
    i_pc = 32'h110;
    smp();
    chk("full_count", o_count, 4);
    chk("full_flag", o_full, 1);
    chk("full_ready_in", ready_in, 0);
    chk("full_head", o_pc, 32'h100);
    tick();
    valid_in = 0;
    smp();
    chk("full_5th_rejected", o_count, 4);
    tick();
    ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("drain_valid", valid_out, 1);
      chk("drain_pc", o_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    smp();
    chk("drain_empty", o_empty, 1);
    chk("drain_count", o_count, 0);
    chk("drain_valid_out", valid_out, 0);

    // steady state: count=2, enq+deq every cycle across pointer wrap
    tick();
    ready_out = 0; valid_in = 1; i_pc = 32'h200;
    tick();
    i_pc = 32'h204;
    tick();
    i_pc = 32'h208; ready_out = 1;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("steady_count", o_count, 2);
      chk("steady_pc", o_pc, 32'h200 + 32'(4 * k));
      tick();
      i_pc = 32'h208 + 32'(4 * (k + 1));
    end
    valid_in = 0; ready_out = 0;
    smp();
    chk("steady_end_count", o_count, 2);
    chk("steady_end_head", o_pc, 32'h228);

    // flush at count=3 with both handshakes offered
    tick();
    valid_in = 1; i_pc = 32'h230;
    tick();
    i_pc = 32'h300; ready_out = 1; flush = 1;
    smp();
    chk("flush_pre_count", o_count, 3);
    chk("flush_valid_out", valid_out, 0);
    chk("flush_ready_in", ready_in, 0);
    tick();
    flush = 0; valid_in = 0; ready_out = 0;
    smp();
    chk("flush_count", o_count, 0);
    chk("flush_empty", o_empty, 1);
    chk("flush_valid_after", valid_out, 0);
    tick();
    valid_in = 1; i_pc = 32'h304;
    smp();
    chk("flush_byp_pc", o_pc, 32'h304);
    tick();
    valid_in = 0;
    smp();
    chk("flush_refill_count", o_count, 1);
    chk("flush_refill_head", o_pc, 32'h304);
    tick();
    ready_out = 1;
    tick();
    ready_out = 0;
    smp();
    chk("flush_refill_pop", o_count, 0);

    // no-bypass latency
    tick();
    nb_valid_in = 1; nb_i_pc = 32'h400; nb_ready_out = 1;
    smp();
    chk("nb_push_valid", nb_valid_out, 0);
    chk("nb_push_count", nb_o_count, 0);
    tick();
    nb_valid_in = 0;
    smp();
    chk("nb_next_valid", nb_valid_out, 1);
    chk("nb_next_pc", nb_o_pc, 32'h400);
    chk("nb_next_count", nb_o_count, 1);
    tick();
    smp();
    chk("nb_pop_count", nb_o_count, 0);
    chk("nb_pop_valid", nb_valid_out, 0);

    // async reset mid-cycle
    tick();
    valid_in = 1; i_pc = 32'h500; ready_out = 0;
    tick();
    i_pc = 32'h504;
    tick();
    valid_in = 0;
    smp();
    chk("arst_pre_count", o_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", o_count, 0);
    chk("arst_valid_out", valid_out, 0);
    chk("arst_ready_in", ready_in, 1);
    chk("arst_empty", o_empty, 1);
    chk("arst_o_pc", o_pc, 0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("arst_after_count", o_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_if_inst_queue.md
Name: core_if_inst_queue

Overview:
Parametrised instruction queue between fetch (core_if_ifu) and decode (core_id_idu). It replaces the single-entry IF/ID handoff with a DEPTH-entry FIFO of {pc, inst, branch_predict}. Fetch can run ahead while decode or execute stalls. A pipeline flush from commit empties the queue in one cycle. An optional bypass mode removes the empty-queue latency.

Parameters:
DEPTH, 4, entry count; power of two, >=2
PC_W, 32, PC width (CORE_PC_WIDTH)
INST_W, 32, instruction width (CORE_INST_WIDTH)
BYPASS, 1, 1 = empty-queue same-cycle pass-through; 0 = always at least one cycle through storage
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  fetch offers an entry
ready_in  out  1  queue accepts an entry
i_pc  in  PC_W  fetched pc
i_inst  in  INST_W  fetched instruction
i_branch_predict  in  1  fetch prediction bit
valid_out  out  1  head entry valid to decode
ready_out  in  1  decode accepts the head entry
o_pc  out  PC_W  head pc
o_inst  out  INST_W  head instruction
o_branch_predict  out  1  head prediction bit
i_pipe_flush_req  in  1  commit flush; discard all entries
o_count  out  CNT_W  current occupancy, 0..DEPTH
o_empty  out  1  o_count==0
o_full  out  1  o_count==DEPTH

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, storage zeroed. Outputs: valid_out=0, o_pc=0, o_inst=0, o_branch_predict=0, o_count=0, o_empty=1, o_full=0, ready_in=1. Reset mid-stream drops all entries immediately, with no partial writes.
- ready_in = !o_full && !i_pipe_flush_req. It does not depend on ready_out, so there is no combinational path ready_out->ready_in.
- enq = valid_in && ready_in. deq = valid_out && ready_out.
- Pointers: log2(DEPTH) bits each, with natural wrap at DEPTH-1 -> 0. Count is a separate CNT_W-bit register. Next count = count + enq_stored - deq_stored.
- Non-bypass path: enq writes storage[wr_ptr] and increments wr_ptr. When count>0, valid_out=1 and the o_* outputs are driven combinationally from storage[rd_ptr]. deq increments rd_ptr.
- Bypass (BYPASS=1, count==0, valid_in=1, no flush):
  - valid_out=1 and o_* = i_* in the same cycle.
  - If ready_out=1, the entry passes through: no storage write, no pointer or count change.
  - If ready_out=0, the entry is stored normally; count becomes 1.
- With BYPASS=0, or count>0: minimum latency in->out is 1 cycle.
- Simultaneous enq and deq with count in 1..DEPTH-1: both pointers advance and count is unchanged.
- Full (count==DEPTH): ready_in=0 even if deq occurs that cycle. Count becomes DEPTH-1 next cycle.
- Empty with BYPASS=0: valid_out=0. The o_* outputs hold storage[rd_ptr] contents; they are don't-care for checking.
- Flush (i_pipe_flush_req=1):
  - Combinationally forces valid_out=0 and ready_in=0.
  - At the next edge, wr_ptr=rd_ptr=0 and count=0; storage is not cleared.
  - Flush dominates every enq/deq in the same cycle; no entry is consumed or written.
- Ordering: strict FIFO. Every accepted entry is presented exactly once unless flushed.
- Assertions: count<=DEPTH; enq never when o_full; deq never when valid_out=0.

Decomposition:
- Shared package/defines: CORE_PC_WIDTH, CORE_INST_WIDTH, and an entry-width macro CORE_IFQ_ENTRY_WIDTH = PC_W+INST_W+1 with bit-field offsets (predict at bit 0, inst next, pc on top).
- One natural sub-module: core_ifq_ram, a DEPTH x ENTRY_W register array with one write port and one asynchronous read port, reset to zero. Control (pointers, count, bypass mux, flush) stays in core_if_inst_queue.

Test Plan:
- Reset, then BYPASS=1, one entry pc=0x8000_0000 inst=0x0000_0013 with ready_out=1 -> valid_out=1 in the same cycle, o_pc=0x8000_0000, o_count stays 0.
- ready_out=0, push 4 entries pc=0x100,0x104,0x108,0x10C -> o_count=4, o_full=1, ready_in=0, 5th offer is not accepted. Then ready_out=1 -> pops in order 0x100..0x10C over 4 cycles and o_empty=1.
- count=2 with simultaneous enq (pc=0x200) and deq, sustained for 10 cycles -> count stays 2 and the pc sequence is preserved across pointer wrap.
- count=3 with i_pipe_flush_req=1 alongside valid_in=1 and ready_out=1 -> same cycle valid_out=0 and ready_in=0. Next cycle o_count=0 and the offered pc=0x300 is absent.
- BYPASS=0, empty, push pc=0x400 with ready_out=1 -> valid_out=0 in the push cycle, valid_out=1 with o_pc=0x400 the following cycle.
- Assert rst_n=0 asynchronously mid-cycle with count=2 -> o_count=0, valid_out=0 and ready_in=1 immediately, before the next clock edge.
